// File: rtl/arithmetic_sequencer.sv
// Bit-serial controller for a 1-bit arithmetic unit: accepts two WIDTH-bit operands
// and an opcode, feeds the unit LSB-first and returns result, carry and signed overflow.
module arithmetic_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow,
  output logic             result_valid,
  input  logic             result_ready,
  output logic             au_a,
  output logic             au_b,
  output logic             au_carry_in,
  output logic [1:0]       au_operation,
  input  logic             au_out,
  input  logic             au_carry_out
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  localparam logic [1:0] OP_DEC = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_INC = 2'b11;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    count_q, count_d;

  // NOTE: every sequential assignment is non-blocking so all flops update
  // from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      op_q     <= '0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      result_q <= result_d;
      op_q     <= op_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
      count_q  <= count_d;
    end
  end

  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_sh_d     = res_sh_q;
    result_d     = result_q;
    op_d         = op_q;
    carry_d      = carry_q;
    ovf_d        = ovf_q;
    cout_d       = cout_q;
    count_d      = count_q;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    au_a         = 1'b0;
    au_b         = 1'b0;
    au_carry_in  = 1'b0;
    au_operation = 2'b00;

    unique case (state_q)
      S_IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = op;
          // SUB and INC need the +1 of two's complement (or the increment) injected at bit 0.
          carry_d = (op == OP_SUB) || (op == OP_INC);
          count_d = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        au_a         = a_sh_q[0];
        au_b         = b_sh_q[0];
        au_carry_in  = carry_q;
        au_operation = op_q;
        res_sh_d     = {au_out, res_sh_q[WIDTH-1:1]};
        a_sh_d       = a_sh_q >> 1;
        b_sh_d       = b_sh_q >> 1;
        carry_d      = au_carry_out;
        count_d      = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          // Outputs are captured separately so they survive the next request's setup.
          result_d = {au_out, res_sh_q[WIDTH-1:1]};
          cout_d   = au_carry_out;
          ovf_d    = carry_q ^ au_carry_out;
          state_d  = S_DONE;
        end
      end

      S_DONE: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign result    = result_q;
  assign carry_out = cout_q;
  assign overflow  = ovf_q;

  logic unused_ops;
  assign unused_ops = (OP_DEC == OP_ADD);

endmodule

// File: tb/tb_arithmetic_sequencer.sv
// Self-checking bench for arithmetic_sequencer at WIDTH=4 and WIDTH=8, each DUT paired
// with a behavioural 1-bit arithmetic unit.
module tb_arithmetic_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_valid;
  logic [7:0] a_in, b_in;
  logic [1:0] op_in;
  logic       result_ready;
  logic       sel8;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic au_bmux(input logic b, input logic [1:0] op);
    case (op)
      2'b00:   return 1'b1;
      2'b01:   return ~b;
      2'b10:   return b;
      default: return 1'b0;
    endcase
  endfunction

  // WIDTH=4 instance
  logic       sr4, rv4, co4, ov4, aua4, aub4, aucin4, auo4, auco4, bm4;
  logic [3:0] res4;
  logic [1:0] auop4;
  assign bm4   = au_bmux(aub4, auop4);
  assign auo4  = aua4 ^ bm4 ^ aucin4;
  assign auco4 = (aua4 & bm4) | (aua4 & aucin4) | (bm4 & aucin4);

  arithmetic_sequencer #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst),
    .start_valid(start_valid & ~sel8), .start_ready(sr4),
    .a(a_in[3:0]), .b(b_in[3:0]), .op(op_in),
    .result(res4), .carry_out(co4), .overflow(ov4),
    .result_valid(rv4), .result_ready(result_ready & ~sel8),
    .au_a(aua4), .au_b(aub4), .au_carry_in(aucin4), .au_operation(auop4),
    .au_out(auo4), .au_carry_out(auco4)
  );

  // WIDTH=8 instance
  logic       sr8, rv8, co8, ov8, aua8, aub8, aucin8, auo8, auco8, bm8;
  logic [7:0] res8;
  logic [1:0] auop8;
  assign bm8   = au_bmux(aub8, auop8);
  assign auo8  = aua8 ^ bm8 ^ aucin8;
  assign auco8 = (aua8 & bm8) | (aua8 & aucin8) | (bm8 & aucin8);

  arithmetic_sequencer #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst),
    .start_valid(start_valid & sel8), .start_ready(sr8),
    .a(a_in), .b(b_in), .op(op_in),
    .result(res8), .carry_out(co8), .overflow(ov8),
    .result_valid(rv8), .result_ready(result_ready & sel8),
    .au_a(aua8), .au_b(aub8), .au_carry_in(aucin8), .au_operation(auop8),
    .au_out(auo8), .au_carry_out(auco8)
  );

  // Observed view of whichever DUT is selected
  logic [7:0] res_m;
  logic       sr_m, rv_m, co_m, ov_m, aua_m, aub_m, aucin_m;
  logic [1:0] auop_m;
  assign res_m   = sel8 ? res8 : {4'b0, res4};
  assign sr_m    = sel8 ? sr8 : sr4;
  assign rv_m    = sel8 ? rv8 : rv4;
  assign co_m    = sel8 ? co8 : co4;
  assign ov_m    = sel8 ? ov8 : ov4;
  assign aua_m   = sel8 ? aua8 : aua4;
  assign aub_m   = sel8 ? aub8 : aub4;
  assign aucin_m = sel8 ? aucin8 : aucin4;
  assign auop_m  = sel8 ? auop8 : auop4;

  // Word-level reference: returns {overflow, carry_out, result[7:0]}
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                       input logic [1:0] op, input int w);
    int mask, lmask, ai, bm, cin, full, low;
    logic [7:0] r;
    logic c, cm;
    mask  = (1 << w) - 1;
    lmask = (1 << (w - 1)) - 1;
    ai    = int'(a) & mask;
    case (op)
      2'b00:   bm = mask;
      2'b01:   bm = ~int'(b) & mask;
      2'b10:   bm = int'(b) & mask;
      default: bm = 0;
    endcase
    cin  = (op == 2'b01 || op == 2'b11) ? 1 : 0;
    full = ai + bm + cin;
    low  = (ai & lmask) + (bm & lmask) + cin;
    r    = 8'(full & mask);
    c    = ((full >> w) & 1) != 0;
    cm   = ((low >> (w - 1)) & 1) != 0;
    return {cm ^ c, c, r};
  endfunction

  // Accepts a request; returns at the negedge right after the accept edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op);
    checks++;
    if (sr_m !== 1'b1) begin
      failures++;
      $display("FAIL issue_start_ready got=%b want=1", sr_m);
    end
    a_in = a; b_in = b; op_in = op; start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_valid = 1'b0;
    a_in = ~a; b_in = ~b; op_in = ~op;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (rv_m !== 1'b1 && n < 40) begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic [1:0] op, input logic [7:0] er, input logic ec,
                        input logic ev);
    int n, w;
    logic prev_ready;
    w = sel8 ? 8 : 4;
    prev_ready = result_ready;
    issue(a, b, op);
    wait_result(n);
    checks++;
    if (n != w) begin
      failures++;
      $display("FAIL %s_latency got=%0d want=%0d", name, n, w);
    end
    checks++;
    if ({res_m, co_m, ov_m} !== {er, ec, ev}) begin
      failures++;
      $display("FAIL %s_value got r=%h c=%b v=%b want r=%h c=%b v=%b",
               name, res_m, co_m, ov_m, er, ec, ev);
    end
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rv_m, sr_m, res_m, co_m, ov_m} !== {1'b0, 1'b1, er, ec, ev}) begin
      failures++;
      $display("FAIL %s_idle got rv=%b sr=%b r=%h want rv=0 sr=1 r=%h",
               name, rv_m, sr_m, res_m, er);
    end
    result_ready = prev_ready;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({res_m, co_m, ov_m, rv_m, sr_m} !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_outputs got r=%h c=%b v=%b rv=%b sr=%b want 00 0 0 0 1",
               res_m, co_m, ov_m, rv_m, sr_m);
    end
    checks++;
    if ({aua_m, aub_m, aucin_m, auop_m} !== 5'b0) begin
      failures++;
      $display("FAIL reset_au got %b%b%b%b want 00000", aua_m, aub_m, aucin_m, auop_m);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_arith;
    sel8 = 1'b0;
    run_op("add_5_3", 8'h5, 8'h3, 2'b10, 8'h8, 1'b0, 1'b1);
    run_op("sub_3_5", 8'h3, 8'h5, 2'b01, 8'hE, 1'b0, 1'b0);
    run_op("sub_5_3", 8'h5, 8'h3, 2'b01, 8'h2, 1'b1, 1'b0);
    run_op("inc_f",   8'hF, 8'h0, 2'b11, 8'h0, 1'b1, 1'b0);
    run_op("dec_8",   8'h8, 8'h0, 2'b00, 8'h7, 1'b1, 1'b1);
  endtask

  task automatic test_backpressure;
    int n;
    sel8 = 1'b0;
    result_ready = 1'b0;
    issue(8'h5, 8'h3, 2'b10);
    wait_result(n);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rv_m, sr_m, res_m, co_m, ov_m} !== {1'b1, 1'b0, 8'h08, 1'b0, 1'b1}) begin
        failures++;
        $display("FAIL bp_hold_%0d got rv=%b sr=%b r=%h c=%b v=%b want 1 0 08 0 1",
                 i, rv_m, sr_m, res_m, co_m, ov_m);
      end
      start_valid = (i == 2);
      a_in = 8'h1; b_in = 8'h1; op_in = 2'b10;
      @(posedge clk);
      @(negedge clk);
      start_valid = 1'b0;
    end
    result_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    result_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({rv_m, sr_m, res_m} !== {1'b0, 1'b1, 8'h08}) begin
      failures++;
      $display("FAIL bp_no_accept got rv=%b sr=%b r=%h want 0 1 08", rv_m, sr_m, res_m);
    end
  endtask

  task automatic test_reset_mid_run;
    sel8 = 1'b0;
    issue(8'h7, 8'h6, 2'b10);
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if ({aua_m, aub_m, aucin_m, auop_m} !== {1'b1, 1'b1, 1'b1, 2'b10}) begin
      failures++;
      $display("FAIL midrun_bit2_au got %b%b%b%b want 11110", aua_m, aub_m, aucin_m, auop_m);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({res_m, co_m, ov_m, rv_m, sr_m, aua_m, aub_m, aucin_m, auop_m}
        !== {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 5'b0}) begin
      failures++;
      $display("FAIL midrun_reset got r=%h c=%b v=%b rv=%b sr=%b au=%b%b%b%b",
               res_m, co_m, ov_m, rv_m, sr_m, aua_m, aub_m, aucin_m, auop_m);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("after_reset_add_1_1", 8'h1, 8'h1, 2'b10, 8'h2, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back;
    logic [9:0] exp;
    logic [7:0] a, b;
    logic [1:0] op;
    result_ready = 1'b1;
    for (int s = 0; s < 2; s++) begin
      sel8 = (s == 1);
      for (int i = 0; i < 10; i++) begin
        a   = 8'($urandom);
        b   = 8'($urandom);
        op  = 2'($urandom);
        if (s == 0) begin
          a = a & 8'h0F;
          b = b & 8'h0F;
        end
        exp = model(a, b, op, sel8 ? 8 : 4);
        run_op(sel8 ? "b2b_w8" : "b2b_w4", a, b, op, exp[7:0], exp[8], exp[9]);
      end
    end
    result_ready = 1'b0;
    sel8 = 1'b0;
  endtask

  initial begin
    start_valid  = 1'b0;
    a_in         = '0;
    b_in         = '0;
    op_in        = '0;
    result_ready = 1'b0;
    sel8         = 1'b0;
    test_reset();
    test_arith();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
